rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum payload bytes per frame (range 1..16000).
REQ-002 SHALL have parameter MIN_LEN, default 46, minimum payload bytes for a frame to be committed (1..MAX_LEN).
REQ-003 rxclk  in  1  receive clock; all logic on its rising edge.
REQ-004 rxrstn  in  1  reset; synchronous, active-low.
REQ-005 rxdv  in  1  frame-active level from the receiver, rising-edge sampled.
REQ-006 din  in  8  received byte, valid with addr.
REQ-007 addr  in  14  payload byte address; header bytes present as wrapped values >= 16358.
REQ-008 wr_en  out  1  buffer write strobe.
REQ-009 wr_bank  out  1  buffer bank being written.
REQ-010 wr_addr  out  14  byte address within bank.
REQ-011 wr_data  out  8  byte to write.
REQ-012 frm_valid  out  1  a committed frame is available.
REQ-013 frm_bank  out  1  bank holding the oldest committed frame.
REQ-014 frm_len  out  14  payload length of that frame.
REQ-015 frm_ready  in  1  consumer release; handshake completes on frm_valid && frm_ready.
REQ-016 drop  out  1  one-cycle pulse per discarded frame.

Function
REQ-017 Payload byte: rxdv=1 and addr < MAX_LEN; SHALL drive wr_en=1, wr_addr=addr, wr_data=din, wr_bank=current bank, all one cycle after sampling.
REQ-018 FSM states IDLE, RECV, DISCARD; transitions evaluated on rxdv edges (rxdv vs. registered rxdv_q).
REQ-019 IDLE: on rising rxdv, -> RECV with bank = write pointer if that bank is free, else -> DISCARD.
REQ-020 RECV: track len = highest payload addr + 1; on rxdv=1 and addr == MAX_LEN, -> DISCARD (overflow).
REQ-021 RECV, falling rxdv: if len >= MIN_LEN, mark bank full, store len, toggle write pointer; else pulse drop; -> IDLE.
REQ-022 DISCARD: wr_en held 0; on falling rxdv pulse drop and -> IDLE; the bank is not marked full.
REQ-023 Banks committed in order; frm_bank/frm_len SHALL reflect oldest full bank (read pointer); frm_valid=1 while that bank is full.
REQ-024 Handshake: on frm_valid && frm_ready, that bank is freed and the read pointer toggles on the same edge; frm_ready without frm_valid is ignored.
REQ-025 Commit and release in the same cycle SHALL both take effect; a bank freed this cycle is not allocatable until the next cycle.
REQ-026 Header addresses (>= 16358) SHALL never write nor affect len.
REQ-027 Each frame produces exactly one commit or one drop pulse, never both.

Reset
REQ-028 On rxrstn=0: state IDLE, both banks free, write and read pointers 0, wr_en=0, wr_bank=0, wr_addr=0, wr_data=0, frm_valid=0, frm_len=0, drop=0.
REQ-029 Reset SHALL load rxdv_q=1, so a frame in progress at reset release is ignored until rxdv falls and rises again.

Configuration
REQ-030 With RX_FRAME_STATS_EN defined: add outputs frm_cnt[15:0] (committed frames) and drop_cnt[15:0] (drop pulses), both reset to 0, saturating at 16'hFFFF.
REQ-031 Without RX_FRAME_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 100-byte frame (addr 16358..16383, then 0..99), frm_ready=0 -> 100 writes bank 0 addr 0..99; frm_valid=1, frm_bank=0, frm_len=100.
REQ-033 Three 64-byte frames, frm_ready=0 -> banks 0 and 1 committed, third produces drop pulse with zero writes.
REQ-034 1600-byte frame -> writes addr 0..1517, overflow at 1518, drop pulse, frm_valid stays 0.
REQ-035 30-byte frame -> 30 writes, drop pulse (below MIN_LEN=46), bank 0 reused by next frame.
REQ-036 Commit of bank 1 on same edge frm_ready releases bank 0 -> frm_valid stays 1, frm_bank=1, bank 0 free.
REQ-037 rxrstn pulsed low mid-frame -> all outputs at reset values; remainder of that frame produces no writes and no drop.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: two-bank receive frame buffer controller with commit/drop handling.
// Optional RX_FRAME_STATS_EN adds saturating frm_cnt/drop_cnt outputs.
module rx_frame_ctrl #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 46
) (
  input  logic        rxclk,
  input  logic        rxrstn,
  input  logic        rxdv,
  input  logic [7:0]  din,
  input  logic [13:0] addr,
  output logic        wr_en,
  output logic        wr_bank,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frm_valid,
  output logic        frm_bank,
  output logic [13:0] frm_len,
  input  logic        frm_ready,
  output logic        drop
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0] frm_cnt,
  output logic [15:0] drop_cnt
`endif
);
  localparam logic [13:0] MAXL = 14'(MAX_LEN);
  localparam logic [13:0] MINL = 14'(MIN_LEN);
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
  state_t      state;
  logic        rxdv_q, wptr, rptr;
  logic [1:0]  full;
  logic [13:0] len;
  logic [13:0] flen [2];
  logic        rise, fall, pay, alloc, take, commit, rel;
  assign rise = rxdv & ~rxdv_q;
  assign fall = ~rxdv & rxdv_q;
  assign pay = rxdv && addr < MAXL;
  assign alloc = state == IDLE && rise && !full[wptr];
  assign take = pay && (alloc || state == RECV);
  assign commit = state == RECV && fall && len >= MINL;
  assign rel = frm_valid && frm_ready;
  assign frm_valid = full[rptr];
  assign frm_bank = rptr;
  assign frm_len = flen[rptr];
  always_ff @(posedge rxclk) begin
    if (!rxrstn) begin
      state   <= IDLE;
      rxdv_q  <= 1'b1;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      full    <= 2'b00;
      len     <= '0;
      flen[0] <= '0;
      flen[1] <= '0;
      wr_en   <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      drop    <= 1'b0;
    end else begin
      rxdv_q <= rxdv;
      wr_en  <= take;
      drop   <= 1'b0;
      if (take) begin
        wr_bank <= wptr;
        wr_addr <= addr;
        wr_data <= din;
      end
      if (alloc) len <= take ? addr + 14'd1 : 14'd0;
      else if (take && addr >= len) len <= addr + 14'd1;
      // release frees the read bank; commit fills the write bank, never the same one
      if (rel) begin
        full[rptr] <= 1'b0;
        rptr       <= ~rptr;
      end
      if (commit) begin
        full[wptr] <= 1'b1;
        flen[wptr] <= len;
        wptr       <= ~wptr;
      end
      case (state)
        IDLE: if (rise) state <= full[wptr] ? DISCARD : RECV;
        RECV:
          if (fall) begin
            state <= IDLE;
            drop  <= !commit;
          end else if (rxdv && addr == MAXL) state <= DISCARD;
        DISCARD:
          if (fall) begin
            state <= IDLE;
            drop  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RX_FRAME_STATS_EN
  always_ff @(posedge rxclk) begin
    if (!rxrstn) begin
      frm_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit && ~&frm_cnt) frm_cnt <= frm_cnt + 16'd1;
      if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: randomized frames checked against a frame-level bank queue model.
module tb_rx_frame_ctrl;
  localparam int MAX = 1518;
  localparam int MIN = 46;
  logic        rxclk = 0, rxrstn = 0, rxdv = 0, frm_ready = 0;
  logic [7:0]  din = 0;
  logic [13:0] addr = 0;
  logic        wr_en, wr_bank, frm_valid, frm_bank, drop;
  logic [13:0] wr_addr, frm_len;
  logic [7:0]  wr_data;
  rx_frame_ctrl dut (
    .rxclk(rxclk), .rxrstn(rxrstn), .rxdv(rxdv), .din(din), .addr(addr),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .frm_valid(frm_valid), .frm_bank(frm_bank), .frm_len(frm_len),
    .frm_ready(frm_ready), .drop(drop)
  );
  always #5 rxclk = ~rxclk;
  typedef struct packed {logic b; logic [13:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic b; logic [13:0] l;} fr_t;
  wr_t expw[$], gotw[$];
  fr_t q[$];
  logic        wbank = 0;
  bit          cpend = 0, dpend = 0, exp_drop = 0;
  logic [13:0] clen = 0;
  int          rdy_pct = 0;
  int          checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit was_rst;
    @(posedge rxclk);
    was_rst = !rxrstn;
    if (was_rst) begin
      q.delete();
      wbank = 0; cpend = 0; dpend = 0; exp_drop = 0;
    end else begin
      if (q.size() > 0 && frm_ready) void'(q.pop_front());
      if (cpend) begin
        q.push_back('{b: wbank, l: clen});
        wbank = ~wbank;
      end
      exp_drop = dpend;
      cpend = 0; dpend = 0;
    end
    @(negedge rxclk);
    if (wr_en) gotw.push_back('{b: wr_bank, a: wr_addr, d: wr_data});
    chk("drop", drop, exp_drop);
    chk("frm_valid", frm_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("frm_bank", frm_bank, q[0].b);
      chk("frm_len", frm_len, q[0].l);
    end
    if (was_rst) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_frm_len", frm_len, 0);
    end
    frm_ready = $urandom_range(99) < rdy_pct;
  endtask
  task automatic frame(input int hdr, input int len, input bit rel_fall = 0, input int rst_at = -1);
    bit acc;
    int n;
    logic [13:0] a;
    n = hdr + len;
    acc = q.size() < 2;
    for (int i = 0; i < n; i++) begin
      a = i < hdr ? 14'(16358 + i) : 14'(i - hdr);
      rxrstn = i != rst_at;
      if (i == rst_at) acc = 0;
      rxdv = 1;
      addr = a;
      din = 8'($urandom);
      if (acc && int'(a) < MAX) expw.push_back('{b: wbank, a: a, d: din});
      tick();
    end
    rxdv = 0;
    rxrstn = 1;
    if (acc && len <= MAX && len >= MIN) begin
      cpend = 1;
      clen = 14'(len);
    end else if (rst_at < 0) dpend = 1;
    if (rel_fall) frm_ready = 1;
    tick();
    repeat ($urandom_range(1, 3)) tick();
    chk("wr_count", gotw.size(), expw.size());
    for (int i = 0; i < gotw.size() && i < expw.size(); i++) chk("wr_rec", gotw[i], expw[i]);
    gotw.delete();
    expw.delete();
  endtask
  initial begin
    int hdr, len, pick;
    repeat (2) tick();
    rxrstn = 1;
    tick();
    frame(26, 100);
    frame(0, 64);
    frame(3, 64);
    rdy_pct = 100;
    repeat (3) tick();
    rdy_pct = 0;
    frame(2, 1600);
    frame(0, 30);
    frame(1, 64);
    frame(0, 80, 1);
    frame(0, 50);
    rdy_pct = 100;
    repeat (3) tick();
    for (int k = 0; k < 30; k++) begin
      pick = $urandom_range(2);
      rdy_pct = pick == 0 ? 0 : pick == 1 ? 25 : 100;
      hdr = $urandom_range(4);
      len = $urandom_range(9) < 2 ? $urandom_range(1500, 1530) : $urandom_range(120);
      if (hdr + len == 0) len = 1;
      frame(hdr, len);
    end
    rdy_pct = 0;
    frame(0, 64);
    frame(2, 60, 0, 20);
    frame(0, 50);
    frame(0, MIN);
    frame(0, MIN - 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
